// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_e       - controller states (IDLE, BUSY, DONE)
//   DEFAULT_WIDTH - default operand/sum width
//   cnt_width()   - bit counter width for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Counter must hold 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: combinational single-bit full-adder cell.
//   a, b - addend bits
//   ci   - carry in
//   s    - sum bit
//   co   - carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one sum bit per clock, LSB first.
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_ready  - operand handshake (in_ready high only in IDLE)
//   A, B, Cin          - operands and carry-in, sampled at the accept edge
//   out_valid/out_ready- result handshake (out_valid high only in DONE)
//   Sum, Cout          - {Cout,Sum} = A + B + Cin
//   Ovf                - signed overflow; present only when SERIAL_ADDER_OVF_EN
//                        is defined
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic fa_s, fa_co;

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // On the MSB bit, carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed self-checking bench for serial_adder.
// Optional feature macro: SERIAL_ADDER_OVF_EN (Ovf checks enabled when defined).
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A, B;
  logic         Cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Sum;
  logic         Cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         Ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .Ovf       (Ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact unsigned sum over W+1 bits.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    int unsigned t;
    t = int'(a) + int'(b) + int'(cin);
    return t[W:0];
  endfunction

  // Reference: signed overflow from the true signed sum leaving the W-bit range.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
    int sa, sb, s;
    sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
    sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
    s  = sa + sb + int'(cin);
    return (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endfunction

  // One full transaction; hold = cycles out_ready stays low in DONE,
  // pulse = drive an in_valid with A=1,B=1 while held in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold, input bit pulse);
    int         cyc;
    bit         seen;
    logic [W:0] e;
    e = ref_sum(a, b, cin);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    A = a; B = b; Cin = cin;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
    check("in_ready_busy", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("latency", cyc, W);
    check("sum", Sum, e[W-1:0]);
    check("cout", Cout, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf", Ovf, ref_ovf(a, b, cin));
`endif
    for (int i = 0; i < hold; i++) begin
      if (pulse && i == 1) begin
        in_valid = 1'b1; A = 1; B = 1; Cin = 1'b0;
      end
      tick();
      in_valid = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", Sum, e[W-1:0]);
      check("hold_cout", Cout, e[W]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("done_exit_valid", out_valid, 0);
    check("done_exit_ready", in_ready, 1);
    check("keep_sum", Sum, e[W-1:0]);
    check("keep_cout", Cout, e[W]);
    if (pulse) begin
      seen = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
        tick();
        if (out_valid) seen = 1'b1;
      end
      check("ignored_pulse", seen, 0);
    end
  endtask

  logic [W-1:0] a_arr [2];
  logic [W-1:0] b_arr [2];
  logic [W:0]   exp_q [$];

  initial begin
    logic [W:0] e;
    int         idx, res, last_acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", Sum, 0);
    check("rst_cout", Cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", Ovf, 0);
`endif

    // Directed cases
    run_op(4'd3, 4'd5, 1'b0, 0, 1'b0);
    run_op(4'hF, 4'd1, 1'b0, 0, 1'b0);
    run_op(4'd7, 4'd1, 1'b0, 0, 1'b0);
    run_op(4'd9, 4'd6, 1'b1, 5, 1'b1);

    // Reset during the second BUSY cycle
    in_valid = 1'b1; A = 4'd6; B = 4'd6; Cin = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", Sum, 0);
    check("midrst_cout", Cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("midrst_ovf", Ovf, 0);
`endif
    run_op(4'd2, 4'd2, 1'b1, 0, 1'b0);

    // Back-to-back with in_valid and out_ready held high
    a_arr[0] = 4'd1;  b_arr[0] = 4'd2;
    a_arr[1] = 4'd10; b_arr[1] = 4'd10;
    idx = 0; res = 0; last_acc = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    A = a_arr[0]; B = b_arr[0]; Cin = 1'b0;
    for (int cyc = 0; cyc < 40 && res < 2; cyc++) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sum(A, B, Cin));
        if (idx > 0) check("b2b_interval", cyc - last_acc, W + 2);
        last_acc = cyc;
        idx++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("b2b_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("b2b_sum", Sum, e[W-1:0]);
          check("b2b_cout", Cout, e[W]);
        end
        res++;
      end
      tick();
      if (idx < 2) begin
        A = a_arr[idx]; B = b_arr[idx];
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_results", res, 2);
    check("b2b_accepts", idx, 2);
    tick();

    // Randomized operands and downstream stalls
    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
